// File: rtl/fu_div_arb_pkg.sv
// Shared types for the divider arbiter: op/result records and the sequencer states.
package fu_div_arb_pkg;

  localparam int DIVARB_MAX_REQ = 8;

  typedef enum logic [1:0] {
    FU_DIV  = 2'd0,
    FU_DIVU = 2'd1,
    FU_REM  = 2'd2,
    FU_REMU = 2'd3
  } div_set_t;

  typedef struct packed {
    div_set_t    op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } fu_input_t;

  typedef struct packed {
    logic [31:0] rdval;
    logic [4:0]  rd;
  } fu_output_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } divarb_state_e;

endpackage

// File: rtl/squash_if.sv
// Pipeline flush bundle; the arbiter only looks at valid.
interface squash_if;
  logic valid;

  modport master (output valid);
  modport slave  (input  valid);
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, searching cyclically.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    int  k;
    logic found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr_i) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/fu_div_arb.sv
// Shares one iterative divider between NREQ issue ports, one op in flight at a time.
//   state | meaning
//   IDLE  | no op held; grant the next requester round-robin
//   ISSUE | latched op presented to the divider until accepted
//   WAIT  | divider busy; result routed to the owning port only
module fu_div_arb
  import fu_div_arb_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 128,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  fu_input_t        req_i [NREQ],
  input  logic [NREQ-1:0]  req_valid_i,
  output logic [NREQ-1:0]  req_ready_o,
  output fu_input_t        div_o,
  output logic             div_valid_o,
  input  logic             div_ready_i,
  input  fu_output_t       div_res_i,
  input  logic             div_res_valid_i,
  output fu_output_t       resp_o,
  output logic [NREQ-1:0]  resp_valid_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] ops_o,
  squash_if.slave          squash_io
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  divarb_state_e    state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  fu_input_t        op_q, op_d;
  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] ops_q, ops_d;

  logic [NREQ-1:0]  gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [NREQ-1:0]  owner_oh;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) owner_oh[i] = (owner_q == IDX_W'(i));
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    op_d         = op_q;
    wd_cnt_d     = wd_cnt_q;
    ops_d        = ops_q;
    req_ready_o  = '0;
    div_valid_o  = 1'b0;
    resp_valid_o = '0;
    if (squash_io.valid) begin
      state_d  = IDLE;
      wd_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_valid_i) begin
            req_ready_o = gnt;
            op_d        = req_i[gnt_idx];
            owner_d     = gnt_idx;
            state_d     = ISSUE;
          end
        end
        ISSUE: begin
          div_valid_o = 1'b1;
          if (div_ready_i) begin
            ops_d    = ops_q + CNT_W'(1);
            wd_cnt_d = '0;
            state_d  = WAIT;
          end
        end
        WAIT: begin
          if (div_res_valid_i) begin
            resp_valid_o = owner_oh;
            rr_ptr_d     = (owner_q == IDX_W'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            state_d      = IDLE;
          end else if (wd_cnt_q != WD_MAX) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // state_q already sits in IDLE during reset; keep the grant from leaking out
    if (!rstn) req_ready_o = '0;
    err_d = err_q | (wd_cnt_d == WD_MAX);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
      ops_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      wd_cnt_q <= wd_cnt_d;
      err_q    <= err_d;
      ops_q    <= ops_d;
    end
  end

  always_ff @(posedge clk) op_q <= op_d;

  assign div_o  = op_q;
  assign resp_o = div_res_i;
  assign busy_o = (state_q != IDLE);
  assign err_o  = err_q;
  assign ops_o  = ops_q;

endmodule

// File: tb/tb_fu_div_arb.sv
// Directed bench for fu_div_arb with a small behavioural divider on the far side.
module tb_fu_div_arb;
  import fu_div_arb_pkg::*;

  localparam int NREQ = 2;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  fu_input_t  req_i [NREQ];
  logic [1:0] req_valid_i;
  logic [1:0] req_ready_o;
  fu_input_t  div_o;
  logic       div_valid_o;
  logic       div_ready_i = 1'b1;
  fu_output_t div_res_i = '0;
  logic       div_res_valid_i = 1'b0;
  fu_output_t resp_o;
  logic [1:0] resp_valid_o;
  logic       busy_o, err_o;
  logic [31:0] ops_o;

  squash_if sq ();

  fu_div_arb #(.NREQ(NREQ), .TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn),
    .req_i(req_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .div_o(div_o), .div_valid_o(div_valid_o), .div_ready_i(div_ready_i),
    .div_res_i(div_res_i), .div_res_valid_i(div_res_valid_i),
    .resp_o(resp_o), .resp_valid_o(resp_valid_o),
    .busy_o(busy_o), .err_o(err_o), .ops_o(ops_o),
    .squash_io(sq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // divider model knobs, written only by the main sequence
  int lat       = 2;
  int stall_cfg = 0;
  bit mute      = 1'b0;

  function automatic logic [31:0] dmodel(fu_input_t x);
    case (x.op)
      FU_DIVU: return (x.rs2 == 0) ? 32'hFFFF_FFFF : x.rs1 / x.rs2;
      FU_REMU: return (x.rs2 == 0) ? x.rs1 : x.rs1 % x.rs2;
      FU_DIV:  return (x.rs2 == 0) ? 32'hFFFF_FFFF : 32'($signed(x.rs1) / $signed(x.rs2));
      default: return (x.rs2 == 0) ? x.rs1 : 32'($signed(x.rs1) % $signed(x.rs2));
    endcase
  endfunction

  // behavioural divider: fixed latency after handshake, optional ready stall, optional silence
  always begin : divider
    bit        hs;
    bit        busy;
    int        cnt;
    int        stall_used;
    fu_input_t cap;
    busy = 1'b0; cnt = 0; stall_used = 0; cap = '0;
    forever begin
      @(negedge clk);
      hs = div_valid_o && div_ready_i;
      if (hs) cap = div_o;
      if (div_valid_o && !div_ready_i) stall_used++;
      @(posedge clk); #1;
      div_res_valid_i = 1'b0;
      if (!rstn) begin
        busy = 1'b0; stall_used = 0;
      end else begin
        if (hs) begin busy = 1'b1; cnt = lat; stall_used = 0; end
        if (busy) begin
          cnt--;
          if (cnt <= 0 && !mute) begin
            div_res_valid_i = 1'b1;
            div_res_i = '{rdval: dmodel(cap), rd: cap.rd};
            busy = 1'b0;
          end
        end
      end
      div_ready_i = !busy && (stall_used >= stall_cfg);
    end
  end

  function automatic logic [1:0] oh(int p);
    return 2'(1 << p);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (resp_valid_o != '0) begin ok = 1'b1; break; end
      step(); #1;
    end
  endtask

  task automatic apply_op(input int p, input fu_input_t op, input logic [31:0] exp);
    bit ok;
    step();
    req_i[p] = op; req_valid_i = oh(p); #1;
    chk("grant", 64'(req_ready_o), 64'(oh(p)));
    step();
    req_valid_i = '0; #1;
    chk("div_valid", 64'(div_valid_o), 64'd1);
    chk("div_o", 64'(div_o == op), 64'd1);
    wait_resp(ok);
    chk("resp_seen", 64'(ok), 64'd1);
    chk("resp_owner", 64'(resp_valid_o), 64'(oh(p)));
    chk("resp_rdval", 64'(resp_o.rdval), 64'(exp));
  endtask

  task automatic do_reset();
    step();
    rstn = 1'b0; #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_ops", 64'(ops_o), 64'd0);
    step(); step();
    rstn = 1'b1; #1;
  endtask

  typedef struct {
    int          port;
    div_set_t    op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  initial begin : main
    vec_t      vecs [6];
    fu_input_t op;
    bit        ok;
    int        waited;
    logic [31:0] ops_b;

    vecs[0] = '{0, FU_DIVU, 32'd100,        32'd7, 32'd14};
    vecs[1] = '{1, FU_REMU, 32'd100,        32'd7, 32'd2};
    vecs[2] = '{0, FU_DIV,  32'hFFFF_FF9C,  32'd7, 32'hFFFF_FFF2};
    vecs[3] = '{1, FU_REM,  32'hFFFF_FF9C,  32'd7, 32'hFFFF_FFFE};
    vecs[4] = '{1, FU_DIVU, 32'hFFFF_FFFF,  32'd1, 32'hFFFF_FFFF};
    vecs[5] = '{0, FU_REMU, 32'd9,          32'd0, 32'd9};

    req_i[0] = '0; req_i[1] = '0;
    req_valid_i = 2'b11;
    sq.valid = 1'b0;

    // reset state, with requests pending to show ready is held low
    step(); #1;
    chk("rst_ready", 64'(req_ready_o), 64'd0);
    chk("rst_div_valid", 64'(div_valid_o), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    chk("rst_ops", 64'(ops_o), 64'd0);
    req_valid_i = '0;
    step();
    rstn = 1'b1; #1;
    chk("idle_ready", 64'(req_ready_o), 64'd0);

    // table of single ops across both ports
    for (int i = 0; i < 6; i++) begin
      op = '{op: vecs[i].op, rs1: vecs[i].a, rs2: vecs[i].b, rd: 5'(i + 1)};
      apply_op(vecs[i].port, op, vecs[i].exp);
    end
    step(); #1;
    chk("ops_after_table", 64'(ops_o), 64'd6);

    // both ports held valid: alternate grants from rr_ptr=0
    do_reset();
    step();
    req_i[0] = '{op: FU_DIVU, rs1: 32'd100, rs2: 32'd7, rd: 5'd1};
    req_i[1] = '{op: FU_DIVU, rs1: 32'd90,  rs2: 32'd9, rd: 5'd2};
    req_valid_i = 2'b11; #1;
    for (int n = 0; n < 4; n++) begin
      waited = 0;
      while (req_ready_o == '0 && waited < 20) begin step(); #1; waited++; end
      chk("rr_grant", 64'(req_ready_o), 64'(oh(n % 2)));
      if (n > 0) chk("rr_back_to_back", 64'(waited), 64'd0);
      step(); #1;
      wait_resp(ok);
      chk("rr_resp_seen", 64'(ok), 64'd1);
      chk("rr_resp_owner", 64'(resp_valid_o), 64'(oh(n % 2)));
      chk("rr_rdval", 64'(resp_o.rdval), (n % 2) ? 64'd10 : 64'd14);
      if (n == 3) req_valid_i = '0;
      step(); #1;
    end
    chk("rr_ops", 64'(ops_o), 64'd4);

    // divider holds ready low for five ISSUE cycles
    stall_cfg = 5;
    step();
    op = '{op: FU_DIVU, rs1: 32'd50, rs2: 32'd5, rd: 5'd3};
    req_i[0] = op; req_valid_i = 2'b01; #1;
    chk("stall_grant", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i = '0; #1;
    ops_b = ops_o;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 64'(div_valid_o), 64'd1);
      chk("stall_div_o", 64'(div_o == op), 64'd1);
      chk("stall_ops", 64'(ops_o), 64'(ops_b));
      step(); #1;
    end
    chk("stall_valid6", 64'(div_valid_o & div_ready_i), 64'd1);
    stall_cfg = 0;
    step(); #1;
    chk("stall_accepted", 64'(ops_o), 64'(ops_b + 32'd1));
    chk("stall_valid_drop", 64'(div_valid_o), 64'd0);
    wait_resp(ok);
    chk("stall_rdval", 64'(resp_o.rdval), 64'd10);
    step(); #1;

    // squash lands in the same cycle as the result; rr_ptr stays at 1
    lat = 3;
    step();
    req_i[0] = '{op: FU_DIVU, rs1: 32'd100, rs2: 32'd7, rd: 5'd4};
    req_valid_i = 2'b01; #1;
    chk("sq_grant", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i = '0; #1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (div_res_valid_i) begin ok = 1'b1; break; end
    end
    chk("sq_result_arrived", 64'(ok), 64'd1);
    sq.valid = 1'b1; #1;
    chk("sq_resp_dropped", 64'(resp_valid_o), 64'd0);
    chk("sq_ready_forced", 64'(req_ready_o), 64'd0);
    step();
    sq.valid = 1'b0;
    req_i[1] = '{op: FU_REMU, rs1: 32'd100, rs2: 32'd7, rd: 5'd5};
    req_valid_i = 2'b11; #1;
    chk("sq_idle", 64'(busy_o), 64'd0);
    chk("sq_regrant", 64'(req_ready_o), 64'd2);
    chk("sq_ops_kept", 64'(ops_o), 64'd6);
    step();
    req_valid_i = '0; #1;
    wait_resp(ok);
    chk("sq_next_owner", 64'(resp_valid_o), 64'd2);
    chk("sq_next_rdval", 64'(resp_o.rdval), 64'd2);
    step();
    sq.valid = 1'b1; req_valid_i = 2'b01; #1;
    chk("sq_req_same_cycle", 64'(req_ready_o), 64'd0);
    step();
    sq.valid = 1'b0; #1;
    chk("sq_req_no_grant", 64'(busy_o), 64'd0);
    chk("sq_req_later", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i = '0; #1;
    wait_resp(ok);
    chk("sq_last_rdval", 64'(resp_o.rdval), 64'd14);
    lat = 2;
    step(); #1;

    // divider never answers: watchdog fires 16 cycles after the handshake
    mute = 1'b1;
    step();
    req_i[0] = '{op: FU_DIV, rs1: 32'd7, rs2: 32'd2, rd: 5'd6};
    req_valid_i = 2'b01; #1;
    chk("wd_grant", 64'(req_ready_o), 64'd1);
    step();
    req_valid_i = '0; #1;
    chk("wd_handshake", 64'(div_valid_o & div_ready_i), 64'd1);
    for (int j = 0; j <= 16; j++) begin
      step(); #1;
      chk("wd_err", 64'(err_o), (j == 16) ? 64'd1 : 64'd0);
    end
    step();
    sq.valid = 1'b1;
    step();
    sq.valid = 1'b0; #1;
    chk("wd_err_sticky", 64'(err_o), 64'd1);
    chk("wd_squash_idle", 64'(busy_o), 64'd0);

    // async reset mid-ISSUE (the silent divider keeps ready low)
    step();
    req_i[1] = '{op: FU_DIVU, rs1: 32'd8, rs2: 32'd2, rd: 5'd7};
    req_valid_i = 2'b10; #1;
    chk("ar_grant", 64'(req_ready_o), 64'd2);
    step();
    req_valid_i = '0; #1;
    chk("ar_issue", 64'(div_valid_o), 64'd1);
    step();
    req_valid_i = 2'b11;
    rstn = 1'b0; #1;
    chk("ar_div_valid", 64'(div_valid_o), 64'd0);
    chk("ar_busy", 64'(busy_o), 64'd0);
    chk("ar_err", 64'(err_o), 64'd0);
    chk("ar_ops", 64'(ops_o), 64'd0);
    chk("ar_ready", 64'(req_ready_o), 64'd0);
    chk("ar_resp_valid", 64'(resp_valid_o), 64'd0);
    step();
    req_valid_i = '0; mute = 1'b0;
    step();
    rstn = 1'b1; #1;
    chk("ar_ops_released", 64'(ops_o), 64'd0);
    chk("ar_err_released", 64'(err_o), 64'd0);

    apply_op(1, '{op: FU_DIVU, rs1: 32'd100, rs2: 32'd7, rd: 5'd8}, 32'd14);
    step(); #1;
    chk("final_ops", 64'(ops_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
